// File: rtl/mem_stage_hs.sv
// mem_stage_hs: memory-access pipeline stage with a req/ack data-memory port.
// Resolves branch-on-zero / branch-on-nonzero, stalls upstream while an access
// is outstanding and owns the MEM/WB register, including a load-data buffer
// used while write-back is held.
// Optional feature: define MEM_TIMEOUT_EN to add an access watchdog that
// abandons an access after TIMEOUT_CYCLES cycles without ack and pulses err_o.
//
// state  | meaning
// IDLE   | no access outstanding; non-memory ops pass straight to MEM/WB
// ACCESS | dm_req_o high, waiting for dm_ack_i
// HOLD   | access done but WB held; load data parked in the buffer
module mem_stage_hs #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int IMM_WIDTH      = 8,
  parameter int REG_WIDTH      = 4,
  parameter int ADDR_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_M_i,
  input  logic [ADDR_WIDTH-1:0] PCM_i,
  input  logic [DATA_WIDTH-1:0] alu_outM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic [IMM_WIDTH-1:0]  immM_i,
  input  logic [REG_WIDTH-1:0]  WriteRegM_i,
  input  logic                  RegWriteM_i,
  input  logic                  BranchM_i,
  input  logic                  BranchNeM_i,
  input  logic                  MemReadM_i,
  input  logic                  MemWriteM_i,
  input  logic                  MovM_i,
  input  logic                  MemSrc_i,
  input  logic [DATA_WIDTH-1:0] ResultW_i,
  input  logic                  stall_MEM_WB_i,
  input  logic                  dm_ack_i,
  input  logic [DATA_WIDTH-1:0] dm_rdata_i,
  output logic                  dm_req_o,
  output logic                  dm_we_o,
  output logic [ADDR_WIDTH-1:0] dm_addr_o,
  output logic [DATA_WIDTH-1:0] dm_wdata_o,
  output logic                  stall_o,
  output logic                  PC_src_o,
  output logic [ADDR_WIDTH-1:0] branchAddr_o,
  output logic [DATA_WIDTH-1:0] WBResult_o,
  output logic [REG_WIDTH-1:0]  WriteReg_o,
  output logic                  RegWrite_o,
  output logic                  valid_W_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t state, state_nxt;

  logic signed [IMM_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_sd;
  logic [ADDR_WIDTH-1:0] imm_sa;
  logic [DATA_WIDTH-1:0] opnd;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [ADDR_WIDTH-1:0] addr_src;
  logic                  memop;
  logic                  is_read;
  logic                  opnd_zero;
  logic                  take;
  logic                  timeout;
  logic                  stall_raw;

  // request registers, held stable for the whole access
  logic                  req_we;
  logic                  req_rd;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [REG_WIDTH-1:0]  req_wreg;
  logic                  req_regwrite;
  logic [DATA_WIDTH-1:0] buf_data;

  logic                  wb_load;
  logic [DATA_WIDTH-1:0] wb_result_nxt;
  logic [REG_WIDTH-1:0]  wb_reg_nxt;
  logic                  wb_rw_nxt;
  logic                  wb_valid_nxt;

  // a nonsensical watchdog limit is caught at elaboration
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_stage_hs: TIMEOUT_CYCLES must be at least 1");
  end

  assign imm_s     = immM_i;
  assign imm_sd    = DATA_WIDTH'(imm_s);
  assign imm_sa    = ADDR_WIDTH'(imm_s);
  assign opnd      = MemSrc_i ? ResultW_i : WriteDataM_i;
  assign alu_res   = MovM_i ? imm_sd : alu_outM_i;
  assign addr_src  = (ADDR_MODE == 1) ? ADDR_WIDTH'(alu_outM_i) : ADDR_WIDTH'(immM_i);
  assign memop     = valid_M_i & (MemReadM_i | MemWriteM_i);
  // write wins when both read and write are set
  assign is_read   = MemReadM_i & ~MemWriteM_i;
  assign opnd_zero = (opnd == '0);
  assign take      = valid_M_i & BranchM_i & ~stall_MEM_WB_i &
                     (BranchNeM_i ? ~opnd_zero : opnd_zero);

  assign branchAddr_o = PCM_i + imm_sa;
  // combinational outputs read 0 while reset is asserted
  assign PC_src_o     = rst & (state == IDLE) & take;
  assign stall_o      = rst & stall_raw;
  assign dm_req_o     = (state == ACCESS);
  assign dm_we_o      = req_we;
  assign dm_addr_o    = req_addr;
  assign dm_wdata_o   = req_wdata;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_INIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // watchdog only fires when WB can take the error bubble; ack has priority
  assign timeout = (state == ACCESS) & (to_cnt == '0) & ~dm_ack_i & ~stall_MEM_WB_i;
  assign err_o   = err_q;

  // down-counter reloaded outside ACCESS, so it restarts on every entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state != ACCESS)
        to_cnt <= TO_INIT;
      else if (to_cnt != '0)
        to_cnt <= to_cnt - 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // next state, upstream stall and MEM/WB next value
  always_comb begin
    state_nxt     = state;
    stall_raw     = 1'b0;
    wb_load       = 1'b0;
    wb_result_nxt = '0;
    wb_reg_nxt    = '0;
    wb_rw_nxt     = 1'b0;
    wb_valid_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          stall_raw = 1'b1;
          state_nxt = ACCESS;
          wb_load   = ~stall_MEM_WB_i;
        end else begin
          stall_raw = stall_MEM_WB_i;
          if (!stall_MEM_WB_i) begin
            wb_load       = 1'b1;
            wb_result_nxt = alu_res;
            wb_reg_nxt    = WriteRegM_i;
            wb_rw_nxt     = RegWriteM_i;
            wb_valid_nxt  = valid_M_i;
          end
        end
      end
      ACCESS: begin
        stall_raw = 1'b1;
        if (dm_ack_i) begin
          if (!stall_MEM_WB_i) begin
            stall_raw     = 1'b0;
            wb_load       = 1'b1;
            wb_result_nxt = req_rd ? dm_rdata_i : '0;
            wb_reg_nxt    = req_wreg;
            wb_rw_nxt     = req_regwrite;
            wb_valid_nxt  = 1'b1;
            state_nxt     = IDLE;
          end else begin
            state_nxt = HOLD;
          end
        end else if (timeout) begin
          stall_raw    = 1'b0;
          wb_load      = 1'b1;
          wb_reg_nxt   = req_wreg;
          wb_valid_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end
      HOLD: begin
        stall_raw = stall_MEM_WB_i;
        if (!stall_MEM_WB_i) begin
          wb_load       = 1'b1;
          wb_result_nxt = buf_data;
          wb_reg_nxt    = req_wreg;
          wb_rw_nxt     = req_regwrite;
          wb_valid_nxt  = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // request registers latch on issue; load data buffered when WB is held at ack
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_we       <= 1'b0;
      req_rd       <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_wreg     <= '0;
      req_regwrite <= 1'b0;
      buf_data     <= '0;
    end else begin
      if (state == IDLE && memop) begin
        req_we       <= MemWriteM_i;
        req_rd       <= is_read;
        req_addr     <= addr_src;
        req_wdata    <= opnd;
        req_wreg     <= WriteRegM_i;
        req_regwrite <= RegWriteM_i & is_read;
      end
      if (state == ACCESS && dm_ack_i && stall_MEM_WB_i)
        buf_data <= req_rd ? dm_rdata_i : '0;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (!rst) begin
      WBResult_o <= '0;
      WriteReg_o <= '0;
      RegWrite_o <= 1'b0;
      valid_W_o  <= 1'b0;
    end else if (wb_load) begin
      WBResult_o <= wb_result_nxt;
      WriteReg_o <= wb_reg_nxt;
      RegWrite_o <= wb_rw_nxt;
      valid_W_o  <= wb_valid_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed bench for mem_stage_hs (ADDR_MODE=1).
// Expected MEM/WB contents are queued when an instruction is driven and
// popped when the stage is due to present it.
module tb_mem_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_M_i;
  logic [7:0]  PCM_i;
  logic [15:0] alu_outM_i;
  logic [15:0] WriteDataM_i;
  logic [7:0]  immM_i;
  logic [3:0]  WriteRegM_i;
  logic        RegWriteM_i, BranchM_i, BranchNeM_i, MemReadM_i, MemWriteM_i, MovM_i, MemSrc_i;
  logic [15:0] ResultW_i;
  logic        stall_MEM_WB_i;
  logic        dm_ack_i;
  logic [15:0] dm_rdata_i;
  logic        dm_req_o, dm_we_o;
  logic [7:0]  dm_addr_o;
  logic [15:0] dm_wdata_o;
  logic        stall_o, PC_src_o;
  logic [7:0]  branchAddr_o;
  logic [15:0] WBResult_o;
  logic [3:0]  WriteReg_o;
  logic        RegWrite_o, valid_W_o, err_o;

  typedef struct packed {
    logic [15:0] result;
    logic [3:0]  wreg;
    logic        rw;
    logic        valid;
  } wb_t;

  wb_t sb[$];
  int  checks = 0;
  int  failures = 0;

  mem_stage_hs #(.ADDR_MODE(1)) dut (
    .clk(clk), .rst(rst), .valid_M_i(valid_M_i), .PCM_i(PCM_i),
    .alu_outM_i(alu_outM_i), .WriteDataM_i(WriteDataM_i), .immM_i(immM_i),
    .WriteRegM_i(WriteRegM_i), .RegWriteM_i(RegWriteM_i), .BranchM_i(BranchM_i),
    .BranchNeM_i(BranchNeM_i), .MemReadM_i(MemReadM_i), .MemWriteM_i(MemWriteM_i),
    .MovM_i(MovM_i), .MemSrc_i(MemSrc_i), .ResultW_i(ResultW_i),
    .stall_MEM_WB_i(stall_MEM_WB_i), .dm_ack_i(dm_ack_i), .dm_rdata_i(dm_rdata_i),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
    .dm_wdata_o(dm_wdata_o), .stall_o(stall_o), .PC_src_o(PC_src_o),
    .branchAddr_o(branchAddr_o), .WBResult_o(WBResult_o), .WriteReg_o(WriteReg_o),
    .RegWrite_o(RegWrite_o), .valid_W_o(valid_W_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input string tag);
    wb_t e;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL %s_sb_empty: observed=0 expected=1", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, 32'(WBResult_o), 32'(e.result));
      chk({tag, "_wreg"},   32'(WriteReg_o), 32'(e.wreg));
      chk({tag, "_rw"},     32'(RegWrite_o), 32'(e.rw));
      chk({tag, "_valid"},  32'(valid_W_o),  32'(e.valid));
    end
  endtask

  task automatic idle_inputs();
    valid_M_i = 0; PCM_i = 0; alu_outM_i = 0; WriteDataM_i = 0; immM_i = 0;
    WriteRegM_i = 0; RegWriteM_i = 0; BranchM_i = 0; BranchNeM_i = 0;
    MemReadM_i = 0; MemWriteM_i = 0; MovM_i = 0; MemSrc_i = 0; ResultW_i = 0;
    stall_MEM_WB_i = 0; dm_ack_i = 0; dm_rdata_i = 0;
  endtask

  task automatic rand_inputs();
    valid_M_i = 1'($urandom); PCM_i = 8'($urandom); alu_outM_i = 16'($urandom);
    WriteDataM_i = 16'($urandom); immM_i = 8'($urandom); WriteRegM_i = 4'($urandom);
    RegWriteM_i = 1'($urandom); BranchM_i = 1'($urandom); BranchNeM_i = 1'($urandom);
    MemReadM_i = 1'($urandom); MemWriteM_i = 1'($urandom); MovM_i = 1'($urandom);
    MemSrc_i = 1'($urandom); ResultW_i = 16'($urandom); stall_MEM_WB_i = 1'($urandom);
    dm_ack_i = 1'($urandom); dm_rdata_i = 16'($urandom);
  endtask

  initial begin
    int n;
    // reset with random inputs
    rst = 1'b0;
    rand_inputs();
    tick();
    rand_inputs();
    tick();
    rand_inputs();
    #1;
    chk("rst_req",    32'(dm_req_o),   0);
    chk("rst_we",     32'(dm_we_o),    0);
    chk("rst_addr",   32'(dm_addr_o),  0);
    chk("rst_wdata",  32'(dm_wdata_o), 0);
    chk("rst_wbres",  32'(WBResult_o), 0);
    chk("rst_wreg",   32'(WriteReg_o), 0);
    chk("rst_rw",     32'(RegWrite_o), 0);
    chk("rst_valid",  32'(valid_W_o),  0);
    chk("rst_err",    32'(err_o),      0);
    chk("rst_stall",  32'(stall_o),    0);
    chk("rst_pcsrc",  32'(PC_src_o),   0);
    rst = 1'b1;
    idle_inputs();
    tick();

    // non-memory ALU result
    valid_M_i = 1; RegWriteM_i = 1; alu_outM_i = 16'h00A5; WriteRegM_i = 4'd5;
    sb.push_back('{16'h00A5, 4'd5, 1'b1, 1'b1});
    #1 chk("alu_stall", 32'(stall_o), 0);
    tick();
    check_wb("alu");
    // MOV: sign-extended immediate
    MovM_i = 1; immM_i = 8'hF0; WriteRegM_i = 4'd6;
    sb.push_back('{16'hFFF0, 4'd6, 1'b1, 1'b1});
    tick();
    check_wb("mov");
    idle_inputs();

    // load, ack in first ACCESS cycle
    valid_M_i = 1; MemReadM_i = 1; RegWriteM_i = 1; WriteRegM_i = 4'd3; alu_outM_i = 16'h0010;
    sb.push_back('{16'hBEEF, 4'd3, 1'b1, 1'b1});
    #1;
    chk("ld_issue_stall", 32'(stall_o), 1);
    chk("ld_issue_req",   32'(dm_req_o), 0);
    tick();
    chk("ld_req",    32'(dm_req_o),  1);
    chk("ld_we",     32'(dm_we_o),   0);
    chk("ld_addr",   32'(dm_addr_o), 32'h10);
    chk("ld_bubble", 32'(valid_W_o), 0);
    BranchM_i = 1; WriteDataM_i = 16'h0000;
    #1 chk("ld_pcsrc_forced0", 32'(PC_src_o), 0);
    BranchM_i = 0;
    dm_ack_i = 1; dm_rdata_i = 16'hBEEF;
    #1 chk("ld_ack_stall", 32'(stall_o), 0);
    tick();
    idle_inputs();
    #1 chk("ld_req_drop", 32'(dm_req_o), 0);
    check_wb("ld");

    // store, forwarded operand, address from ALU, ack in third ACCESS cycle
    valid_M_i = 1; MemWriteM_i = 1; MemSrc_i = 1; ResultW_i = 16'h1234;
    WriteDataM_i = 16'hFFFF; alu_outM_i = 16'h0042; RegWriteM_i = 1; WriteRegM_i = 4'd7;
    sb.push_back('{16'h0000, 4'd7, 1'b0, 1'b1});
    #1 chk("st_issue_stall", 32'(stall_o), 1);
    tick();
    ResultW_i = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      chk("st_req",   32'(dm_req_o),   1);
      chk("st_we",    32'(dm_we_o),    1);
      chk("st_addr",  32'(dm_addr_o),  32'h42);
      chk("st_wdata", 32'(dm_wdata_o), 32'h1234);
      if (i == 2) begin
        dm_ack_i = 1; dm_rdata_i = 16'hFFFF;
        #1 chk("st_ack_stall", 32'(stall_o), 0);
      end else begin
        chk("st_wait_stall", 32'(stall_o), 1);
      end
      tick();
    end
    idle_inputs();
    check_wb("st");

    // load acked while WB is held -> HOLD
    valid_M_i = 1; MemReadM_i = 1; RegWriteM_i = 1; WriteRegM_i = 4'd9; alu_outM_i = 16'h0020;
    sb.push_back('{16'hCAFE, 4'd9, 1'b1, 1'b1});
    tick();
    stall_MEM_WB_i = 1; dm_ack_i = 1; dm_rdata_i = 16'hCAFE;
    #1 chk("hold_ack_stall", 32'(stall_o), 1);
    tick();
    dm_rdata_i = 16'h0BAD;
    #1;
    chk("hold_req",    32'(dm_req_o),  0);
    chk("hold_stall1", 32'(stall_o),   1);
    chk("hold_valid",  32'(valid_W_o), 0);
    tick();
    dm_ack_i = 0;
    #1 chk("hold_stall2", 32'(stall_o), 1);
    tick();
    stall_MEM_WB_i = 0;
    #1;
    chk("hold_release_stall", 32'(stall_o), 0);
    chk("hold_release_valid", 32'(valid_W_o), 0);
    tick();
    idle_inputs();
    check_wb("hold");

    // branch resolution (combinational)
    valid_M_i = 1; BranchM_i = 1; BranchNeM_i = 1; WriteDataM_i = 16'd5; PCM_i = 8'hFE; immM_i = 8'h04;
    #1;
    chk("bne_taken", 32'(PC_src_o), 1);
    chk("bne_addr",  32'(branchAddr_o), 32'h02);
    WriteDataM_i = 16'd0;
    #1 chk("bne_zero", 32'(PC_src_o), 0);
    BranchNeM_i = 0;
    #1 chk("beq_zero", 32'(PC_src_o), 1);
    stall_MEM_WB_i = 1;
    #1 chk("beq_wb_stall", 32'(PC_src_o), 0);
    stall_MEM_WB_i = 0; BranchNeM_i = 1; MemSrc_i = 1; ResultW_i = 16'd0; WriteDataM_i = 16'd5;
    #1 chk("bne_fwd_zero", 32'(PC_src_o), 0);
    PCM_i = 8'h10; immM_i = 8'hF0;
    #1 chk("br_neg_addr", 32'(branchAddr_o), 32'h00);
    idle_inputs();
    tick();

    // reset mid-ACCESS, then a late ack must be ignored
    valid_M_i = 1; MemReadM_i = 1; RegWriteM_i = 1; WriteRegM_i = 4'd2; alu_outM_i = 16'h0030;
    tick();
    chk("rma_req", 32'(dm_req_o), 1);
    rst = 1'b0;
    tick();
    #1;
    chk("rma_req_drop", 32'(dm_req_o),  0);
    chk("rma_stall",    32'(stall_o),   0);
    chk("rma_valid",    32'(valid_W_o), 0);
    rst = 1'b1;
    idle_inputs();
    dm_ack_i = 1; dm_rdata_i = 16'hDEAD;
    tick();
    dm_ack_i = 0;
    #1;
    chk("late_ack_req",   32'(dm_req_o),   0);
    chk("late_ack_res",   32'(WBResult_o), 0);
    chk("late_ack_rw",    32'(RegWrite_o), 0);
    chk("late_ack_stall", 32'(stall_o),    0);

`ifdef MEM_TIMEOUT_EN
    // no ack: watchdog abandons after 16 ACCESS cycles
    valid_M_i = 1; MemReadM_i = 1; RegWriteM_i = 1; WriteRegM_i = 4'd4; alu_outM_i = 16'h0050;
    sb.push_back('{16'h0000, 4'd4, 1'b0, 1'b1});
    tick();
    n = 0;
    while (dm_req_o === 1'b1 && n < 40) begin
      chk("to_err_early", 32'(err_o), 0);
      n++;
      tick();
    end
    idle_inputs();
    chk("to_req_cycles", 32'(n), 16);
    chk("to_err_pulse", 32'(err_o), 1);
    check_wb("to");
    tick();
    chk("to_err_once", 32'(err_o), 0);
`else
    n = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
